fu_pipe_scheduler: RTL and testbench

Issue scheduler for a shared, fixed-latency, fully pipelined functional unit (e.g. the multiplier). It arbitrates round-robin among NUM_REQ reservation-station requesters and drives one operation per cycle into the unit. It tracks each in-flight tag through a delay line matched to the unit latency. Returned results are buffered in a credit-protected FIFO that drains to the result bus under a valid/ready handshake.

---
 rtl/fu_sched_pkg.sv | 31 +++
 rtl/fu_pipe_scheduler_if.sv | 50 +++++
 rtl/fu_tag_delay.sv | 47 ++++
 rtl/fu_pipe_scheduler.sv | 168 ++++++++++++++++
 tb/tb_fu_pipe_scheduler.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fu_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fu_sched_pkg
//  Description : Shared constants, helpers and types for the functional-unit
//                issue scheduler (default parameters, credit-counter width
//                helper, result FIFO entry layout).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fu_sched_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = 5;
    localparam int DEF_LATENCY    = 3;
    localparam int DEF_BUF_DEPTH  = 4;

    // Width needed to hold any value in 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Result FIFO entry at the default widths. Instances built with other
    // widths declare the same {tag, data} layout locally.
    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] data;
    } res_entry_t;

endpackage
`default_nettype wire

// File: rtl/fu_pipe_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : fu_pipe_scheduler_if
//  Description : Bundle of requester, functional-unit and result-bus signals
//                around the issue scheduler.
//  Ports       : none; modports
//                  slave  - scheduler side (takes requests, drives unit and
//                           result bus)
//                  master - environment side (requesters, unit, consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fu_pipe_scheduler_if
    import fu_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) ();

    // Requesters
    logic [NUM_REQ-1:0]                 req_valid_i;
    logic [NUM_REQ-1:0][TAG_WIDTH-1:0]  req_tag_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b_i;
    logic [NUM_REQ-1:0]                 req_grant_o;

    // Functional unit
    logic                               fu_valid_o;
    logic [DATA_WIDTH-1:0]              fu_a_o;
    logic [DATA_WIDTH-1:0]              fu_b_o;
    logic [DATA_WIDTH-1:0]              fu_result_i;

    // Result bus
    logic                               res_valid_o;
    logic [TAG_WIDTH-1:0]               res_tag_o;
    logic [DATA_WIDTH-1:0]              res_data_o;
    logic                               res_ready_i;

    modport slave (
        input  req_valid_i, req_tag_i, req_a_i, req_b_i, fu_result_i, res_ready_i,
        output req_grant_o, fu_valid_o, fu_a_o, fu_b_o, res_valid_o, res_tag_o, res_data_o
    );

    modport master (
        output req_valid_i, req_tag_i, req_a_i, req_b_i, fu_result_i, res_ready_i,
        input  req_grant_o, fu_valid_o, fu_a_o, fu_b_o, res_valid_o, res_tag_o, res_data_o
    );

endinterface
`default_nettype wire

// File: rtl/fu_tag_delay.sv
`default_nettype none
// ============================================================================
//  Module      : fu_tag_delay
//  Description : LATENCY-stage {valid, tag} shift register that follows each
//                issued operation through the functional-unit pipeline.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                in_valid/tag  - issue this cycle and its destination tag
//                out_valid/tag - operation whose result is on the unit
//                                output this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_tag_delay #(
    parameter int LATENCY   = 3,
    parameter int TAG_WIDTH = 5
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  in_valid,
    input  wire  [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    output logic [TAG_WIDTH-1:0] out_tag
);

    logic [LATENCY-1:0]   r_valid;
    logic [TAG_WIDTH-1:0] r_tag [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_tag[0]   <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign out_tag   = r_tag[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/fu_pipe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fu_pipe_scheduler
//  Description : Round-robin issue scheduler for a shared, fixed-latency,
//                fully pipelined functional unit. Results are collected in a
//                credit-protected FIFO drained by a valid/ready result bus.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                bus  - fu_pipe_scheduler_if.slave (requests/grant, unit
//                       operands/result, result bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_pipe_scheduler
    import fu_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input wire                 clk,
    input wire                 rst,
    fu_pipe_scheduler_if.slave bus
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W  = PTR_W + 1;
    localparam int CRED_W = credit_width(BUF_DEPTH);
    localparam int AW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]   r_ptr;
    logic [CRED_W-1:0]  r_credits;
    logic [IDX_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_any;
    logic               w_issue;
    logic [NUM_REQ-1:0] w_grant;

    // Scan from the pointer upward, wrapping; first valid requester wins.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + IDX_W'(k);
            if (w_idx >= IDX_W'(NUM_REQ)) begin
                w_idx = w_idx - IDX_W'(NUM_REQ);
            end
            if (!w_any && bus.req_valid_i[w_idx[PTR_W-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_idx[PTR_W-1:0];
            end
        end
    end

    // rst gates the combinational path so outputs read 0 immediately on an
    // asynchronous reset, not just after the next edge.
    assign w_issue = !rst && w_any && (r_credits != '0);

    always_comb begin
        w_grant = '0;
        if (w_issue) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign bus.req_grant_o = w_grant;
    assign bus.fu_valid_o  = w_issue;
    assign bus.fu_a_o      = w_issue ? bus.req_a_i[w_gidx] : '0;
    assign bus.fu_b_o      = w_issue ? bus.req_b_i[w_gidx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // In-flight tag tracking
    // ------------------------------------------------------------------
    logic                 w_fifo_wr;
    logic [TAG_WIDTH-1:0] w_ret_tag;

    fu_tag_delay #(
        .LATENCY   (LATENCY),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_issue),
        .in_tag    (bus.req_tag_i[w_gidx]),
        .out_valid (w_fifo_wr),
        .out_tag   (w_ret_tag)
    );

    // ------------------------------------------------------------------
    // Result FIFO. Every write was preceded by a credit taken at issue, so
    // occupancy can never exceed BUF_DEPTH and no full check is needed.
    // ------------------------------------------------------------------
    entry_t            r_mem [BUF_DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CRED_W-1:0] r_count;
    logic              w_res_valid;
    logic              w_res_hs;

    assign w_res_valid = (r_count != '0);
    assign w_res_hs    = w_res_valid && bus.res_ready_i;

    // Storage needs no reset: r_count decides what is visible.
    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_tail] <= '{tag: w_ret_tag, data: bus.fu_result_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_tail <= (r_tail == AW'(BUF_DEPTH - 1)) ? '0 : r_tail + AW'(1);
            end
            if (w_res_hs) begin
                r_head <= (r_head == AW'(BUF_DEPTH - 1)) ? '0 : r_head + AW'(1);
            end
            case ({w_fifo_wr, w_res_hs})
                2'b10:   r_count <= r_count + CRED_W'(1);
                2'b01:   r_count <= r_count - CRED_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.res_valid_o = w_res_valid;
    assign bus.res_tag_o   = w_res_valid ? r_mem[r_head].tag  : '0;
    assign bus.res_data_o  = w_res_valid ? r_mem[r_head].data : '0;

    // ------------------------------------------------------------------
    // Issue credits: one per FIFO slot, returned when the result leaves.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= CRED_W'(BUF_DEPTH);
        end else begin
            case ({w_issue, w_res_hs})
                2'b10:   r_credits <= r_credits - CRED_W'(1);
                2'b01:   r_credits <= r_credits + CRED_W'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fu_pipe_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fu_pipe_scheduler
//  Description : Self-checking bench for fu_pipe_scheduler. An issue checker
//                predicts grants from a round-robin/credit model, plays the
//                functional unit (product after LATENCY cycles) and pushes the
//                expected result into a scoreboard queue; a result monitor
//                pops and compares whenever the result bus is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_pipe_scheduler;
    import fu_sched_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 5;
    localparam int LATENCY    = 3;
    localparam int BUF_DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fu_pipe_scheduler_if #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)
    ) bus ();

    fu_pipe_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH),
        .LATENCY(LATENCY), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
        int                    vis;   // first cycle the result may be shown
    } exp_t;

    exp_t                  exp_q[$];
    logic [DATA_WIDTH-1:0] fu_pending [int];   // unit output keyed by cycle

    int cyc       = 0;
    int n_tests   = 0;
    int n_fail    = 0;
    int n_issued  = 0;
    int n_popped  = 0;
    int m_credits = BUF_DEPTH;
    int m_ptr     = 0;
    int grant_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter and start-of-cycle credit snapshot.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        m_credits <= BUF_DEPTH - (n_issued - n_popped);
    end

    // Functional-unit model: drives the product LATENCY cycles after issue,
    // random junk otherwise.
    always @(posedge clk) begin
        #1;
        if (fu_pending.exists(cyc)) begin
            bus.fu_result_i = fu_pending[cyc];
            fu_pending.delete(cyc);
        end else begin
            bus.fu_result_i = DATA_WIDTH'($urandom);
        end
    end

    // Issue checker: predicts the grant and records the expected result.
    always @(negedge clk) begin
        int                 g;
        int                 idx;
        logic [NUM_REQ-1:0] exp_grant;
        exp_t               e;
        if (!rst) begin
            g = -1;
            if (m_credits > 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && bus.req_valid_i[idx]) g = idx;
                end
            end
            exp_grant = '0;
            if (g >= 0) exp_grant[g] = 1'b1;
            check("grant", 64'(bus.req_grant_o), 64'(exp_grant));
            check("fu_valid", 64'(bus.fu_valid_o), 64'(g >= 0));
            check("fu_a", 64'(bus.fu_a_o), (g >= 0) ? 64'(bus.req_a_i[g]) : 64'd0);
            check("fu_b", 64'(bus.fu_b_o), (g >= 0) ? 64'(bus.req_b_i[g]) : 64'd0);
            if (g >= 0) begin
                e.tag  = bus.req_tag_i[g];
                e.data = bus.req_a_i[g] * bus.req_b_i[g];
                e.vis  = cyc + LATENCY + 1;
                exp_q.push_back(e);
                fu_pending[cyc + LATENCY] = bus.fu_a_o * bus.fu_b_o;
                n_issued++;
                grant_cnt++;
                m_ptr = (g + 1) % NUM_REQ;
            end
        end
    end

    // Result monitor: compares the FIFO head against the scoreboard.
    always @(negedge clk) begin
        logic ev;
        if (!rst) begin
            ev = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
            check("res_valid", 64'(bus.res_valid_o), 64'(ev));
            if (ev && bus.res_valid_o) begin
                check("res_tag", 64'(bus.res_tag_o), 64'(exp_q[0].tag));
                check("res_data", 64'(bus.res_data_o), 64'(exp_q[0].data));
                if (bus.res_ready_i) begin
                    void'(exp_q.pop_front());
                    n_popped++;
                end
            end
        end
    end

    task automatic drive(input logic [NUM_REQ-1:0] v, input logic rdy);
        @(posedge clk);
        #1;
        bus.req_valid_i = v;
        bus.res_ready_i = rdy;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_tag_i[k] = TAG_WIDTH'($urandom);
            bus.req_a_i[k]   = DATA_WIDTH'($urandom);
            bus.req_b_i[k]   = DATA_WIDTH'($urandom);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, " grant"},    64'(bus.req_grant_o), 64'd0);
        check({pfx, " fu_valid"}, 64'(bus.fu_valid_o),  64'd0);
        check({pfx, " fu_a"},     64'(bus.fu_a_o),      64'd0);
        check({pfx, " fu_b"},     64'(bus.fu_b_o),      64'd0);
        check({pfx, " res_valid"},64'(bus.res_valid_o), 64'd0);
        check({pfx, " res_tag"},  64'(bus.res_tag_o),   64'd0);
        check({pfx, " res_data"}, 64'(bus.res_data_o),  64'd0);
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_tag_i   = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.res_ready_i = 1'b0;
        bus.fu_result_i = '0;

        // Reset state, with requests pending to show grants are held off.
        bus.req_valid_i = '1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");

        // Single request from requester 2: tag 7, 3*5.
        rst             = 1'b0;
        bus.req_valid_i = 4'b0100;
        bus.req_tag_i[2] = 5'd7;
        bus.req_a_i[2]  = 32'd3;
        bus.req_b_i[2]  = 32'd5;
        bus.res_ready_i = 1'b1;
        #1;
        check("single grant", 64'(bus.req_grant_o), 64'h4);
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
        repeat (3) @(posedge clk);
        #2;
        check("single res_valid", 64'(bus.res_valid_o), 64'd1);
        check("single res_tag",   64'(bus.res_tag_o),   64'd7);
        check("single res_data",  64'(bus.res_data_o),  64'd15);

        // Wrap-around: pointer is now 3; only requesters 1 and 3 request.
        repeat (4) drive('0, 1'b1);
        drive(4'b1010, 1'b1);
        #1;
        check("wrap grant 3", 64'(bus.req_grant_o), 64'h8);
        drive(4'b1010, 1'b1);
        #1;
        check("wrap grant 1", 64'(bus.req_grant_o), 64'h2);

        // All requesters continuously, consumer always ready.
        repeat (20) drive('1, 1'b1);
        repeat (8)  drive('0, 1'b1);

        // Consumer stalled: exactly BUF_DEPTH issues, then nothing.
        grant_cnt = 0;
        repeat (12) drive('1, 1'b0);
        check("stall grants", 64'(grant_cnt), 64'(BUF_DEPTH));
        drive('1, 1'b1);                 // one handshake
        repeat (6) drive('1, 1'b0);
        check("resume grants", 64'(grant_cnt), 64'(BUF_DEPTH + 1));

        // Randomised traffic.
        repeat (250) drive(NUM_REQ'($urandom), $urandom_range(0, 3) != 0);

        // Mid-operation reset with results in flight and buffered.
        repeat (6) drive('1, 1'b1);
        repeat (2) drive('1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("async reset");
        exp_q.delete();
        n_issued  = 0;
        n_popped  = 0;
        m_ptr     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        grant_cnt = 0;
        repeat (11) drive('1, 1'b0);
        check("post-reset credits", 64'(grant_cnt), 64'(BUF_DEPTH));

        repeat (150) drive(NUM_REQ'($urandom), $urandom_range(0, 2) != 0);
        repeat (12)  drive('0, 1'b1);
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
